// File: rtl/mode_display_mux_pkg.sv
// Shared clock-app definitions: display blanking constants, mode indices and
// the mode-select width helper used by mode_display_mux.
package mode_display_mux_pkg;

   localparam int SEG_MAX_W = 64;

   // Wide constants; consumers slice off the width they need.
   localparam logic [SEG_MAX_W-1:0] SEG_BLANK_DATA = '0;
   localparam logic [SEG_MAX_W-1:0] SEG_COM_OFF    = '1;

   typedef enum logic [2:0] {
      MODE_WATCH     = 3'd0,
      MODE_STOPWATCH = 3'd1,
      MODE_ALARM     = 3'd2
   } mode_e;

   function automatic int sel_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/mode_display_mux_btn_debounce.sv
// Button conditioner: 2-FF synchroniser, consecutive-cycle debounce counter and
// stable level; emits a one-cycle pulse on each accepted 0->1 transition.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 20
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic rise
);

   localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

   logic             sync1_reg;
   logic             sync2_reg;
   logic             stable_reg;
   logic             rise_reg;
   logic [CNT_W-1:0] cnt_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_reg  <= 1'b0;
         sync2_reg  <= 1'b0;
         stable_reg <= 1'b0;
         rise_reg   <= 1'b0;
         cnt_reg    <= '0;
      end else begin
         sync1_reg <= btn;
         sync2_reg <= sync1_reg;
         rise_reg  <= 1'b0;
         if (sync2_reg == stable_reg) begin
            cnt_reg <= '0;
         end else if (cnt_reg == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            // This cycle is the DEBOUNCE_CYCLES-th differing one: accept the level.
            cnt_reg    <= '0;
            stable_reg <= ~stable_reg;
            rise_reg   <= ~stable_reg;
         end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
         end
      end
   end

   assign rise = rise_reg;

endmodule

// File: rtl/mode_display_mux.sv
// Mode sequencer and 7-segment source mux with debounce, lock and blanking.
// Define MODE_REVERSE_EN to add the mode_prev_btn input (step backwards).
module mode_display_mux
   import mode_display_mux_pkg::*;
#(
   parameter int  NUM_MODES       = 3,
   parameter int  SEG_W           = 8,
   parameter int  COM_W           = 8,
   parameter int  DEBOUNCE_CYCLES = 20,
   parameter int  BLANK_CYCLES    = 2,
   localparam int SEL_W           = sel_width(NUM_MODES)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       mode_btn,
`ifdef MODE_REVERSE_EN
   input  logic                       mode_prev_btn,
`endif
   input  logic                       mode_lock,
   input  logic [NUM_MODES*SEG_W-1:0] src_seg_data,
   input  logic [NUM_MODES*COM_W-1:0] src_seg_com,
   output logic [SEG_W-1:0]           seg_data,
   output logic [COM_W-1:0]           seg_com,
   output logic [SEL_W-1:0]           mode_sel,
   output logic [NUM_MODES-1:0]       mode_led,
   output logic                       mode_changed
);

   localparam int               BLANK_W   = (BLANK_CYCLES < 2) ? 1 : $clog2(BLANK_CYCLES + 1);
   localparam logic [SEL_W-1:0] LAST_MODE = SEL_W'(NUM_MODES - 1);

   logic               next_rise;
   logic               prev_rise;
   logic [SEL_W-1:0]   mode_sel_reg, mode_sel_next;
   logic               mode_changed_reg, mode_changed_next;
   logic [BLANK_W-1:0] blank_cnt_reg, blank_cnt_next;
   logic [SEG_W-1:0]   seg_data_reg, seg_data_next;
   logic [COM_W-1:0]   seg_com_reg, seg_com_next;

   logic [SEG_W-1:0]   src_data [NUM_MODES];
   logic [COM_W-1:0]   src_com  [NUM_MODES];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_MODES; gi++) begin : g_src
         assign src_data[gi] = src_seg_data[gi*SEG_W +: SEG_W];
         assign src_com[gi]  = src_seg_com[gi*COM_W +: COM_W];
         assign mode_led[gi] = (mode_sel_reg == SEL_W'(gi));
      end
   endgenerate

   btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_next_btn (
      .clk (clk),
      .rst (rst),
      .btn (mode_btn),
      .rise(next_rise)
   );

`ifdef MODE_REVERSE_EN
   btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_prev_btn (
      .clk (clk),
      .rst (rst),
      .btn (mode_prev_btn),
      .rise(prev_rise)
   );
`else
   assign prev_rise = 1'b0;
`endif

   always_comb begin
      mode_sel_next     = mode_sel_reg;
      mode_changed_next = 1'b0;
      blank_cnt_next    = blank_cnt_reg;
      seg_data_next     = SEG_BLANK_DATA[SEG_W-1:0];
      seg_com_next      = SEG_COM_OFF[COM_W-1:0];

      if (blank_cnt_reg != '0) begin
         blank_cnt_next = blank_cnt_reg - BLANK_W'(1);
      end

      // Simultaneous next/prev presses cancel; a locked press is simply dropped.
      if (!mode_lock && (next_rise != prev_rise)) begin
         mode_changed_next = 1'b1;
         blank_cnt_next    = BLANK_W'(BLANK_CYCLES);
         if (next_rise) begin
            mode_sel_next = (mode_sel_reg == LAST_MODE) ? '0 : mode_sel_reg + SEL_W'(1);
         end else begin
            mode_sel_next = (mode_sel_reg == '0) ? LAST_MODE : mode_sel_reg - SEL_W'(1);
         end
      end

      // Blank exactly while the registered counter will be nonzero.
      if (blank_cnt_next == '0) begin
         seg_data_next = src_data[mode_sel_next];
         seg_com_next  = src_com[mode_sel_next];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mode_sel_reg     <= SEL_W'(MODE_WATCH);
         mode_changed_reg <= 1'b0;
         blank_cnt_reg    <= '0;
         seg_data_reg     <= SEG_BLANK_DATA[SEG_W-1:0];
         seg_com_reg      <= SEG_COM_OFF[COM_W-1:0];
      end else begin
         mode_sel_reg     <= mode_sel_next;
         mode_changed_reg <= mode_changed_next;
         blank_cnt_reg    <= blank_cnt_next;
         seg_data_reg     <= seg_data_next;
         seg_com_reg      <= seg_com_next;
      end
   end

   assign mode_sel     = mode_sel_reg;
   assign mode_changed = mode_changed_reg;
   assign seg_data     = seg_data_reg;
   assign seg_com      = seg_com_reg;

endmodule
